regfile_writeback: RTL

- Write-side initiator for the 32x32 register file. It accepts writeback results from the load unit and the ALU and queues them in a small in-order FIFO.
- It issues at most one register-file write per cycle on the rf_we/rf_rd/rf_di port.
- It provides bypass lookups so that read-port consumers see queued writes that have not yet committed.
- It sits between the execute/memory stages and the register file.

---
 rtl/regfile_writeback.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback
// Write-side initiator for the 32-entry register file. Writebacks from the
// load unit and the ALU are queued in an in-order FIFO. The FIFO drains one
// entry per cycle into the register file write port, and queued entries can
// be looked up so that readers see writes that have not committed yet.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   ld_valid/ld_rd/ld_data load writeback request; ld_ready accepts it
//   alu_valid/alu_rd/...   ALU writeback request; alu_ready accepts it
//                          (the load unit always wins when both are valid)
//   stall                  register file busy: hold the queue
//   rf_we/rf_rd/rf_di      register file write port, driven from the head
//   ra/rb                  bypass lookup addresses
//   fwd_*_hit/fwd_*_data   youngest queued value for each lookup address
//   count                  number of queued entries
module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     ld_ready,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    output logic                     alu_ready,
    input  logic                     stall,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_di,
    input  logic [4:0]               ra,
    input  logic [4:0]               rb,
    output logic                     fwd_a_hit,
    output logic [XLEN-1:0]          fwd_a_data,
    output logic                     fwd_b_hit,
    output logic [XLEN-1:0]          fwd_b_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Entry storage carries no reset; validity is defined by count/pointers.
    logic [4:0]      rd_mem   [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic            full;
    logic            empty;
    logic            push_hs;
    logic            push_en;
    logic            pop;
    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;
    logic [AW-1:0]   scan_idx;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;

    // The ALU can only handshake when ld_valid is low, so ld_valid alone
    // selects the source of the accepted writeback.
    assign push_rd   = ld_valid ? ld_rd   : alu_rd;
    assign push_data = ld_valid ? ld_data : alu_data;
    assign push_hs   = (ld_valid && ld_ready) || (alu_valid && alu_ready);
    // Writes to x0 complete the handshake but are never stored.
    assign push_en   = push_hs && (push_rd != 5'd0);

    assign rf_we = !empty && !stall;
    assign rf_rd = rd_mem[rd_ptr_q];
    assign rf_di = data_mem[rd_ptr_q];
    assign pop   = rf_we;

    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_en) - CW'(pop);
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            rd_mem[wr_ptr_q]   <= push_rd;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    // Walk valid entries oldest to youngest; a later match overwrites an
    // earlier one, so the result is the youngest matching entry.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                if ((ra != 5'd0) && (rd_mem[scan_idx] == ra)) begin
                    fwd_a_hit  = 1'b1;
                    fwd_a_data = data_mem[scan_idx];
                end
                if ((rb != 5'd0) && (rd_mem[scan_idx] == rb)) begin
                    fwd_b_hit  = 1'b1;
                    fwd_b_data = data_mem[scan_idx];
                end
            end
        end
    end

endmodule
